// File: rtl/cardinal_nic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cardinal_nic                                                 |
// | Description : NIC between a processor core and a ring router PE port; an   |
// |               input FIFO filled by the router, an output FIFO drained by   |
// |               the router under even/odd polarity, and a 4-word reg map.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int IN_DEPTH   = 2,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam int c_IN_PW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int c_IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int c_OUT_PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int c_OUT_CW = $clog2(OUT_DEPTH) + 1;

    localparam logic [c_IN_PW-1:0]  c_IN_LAST  = c_IN_PW'(IN_DEPTH - 1);
    localparam logic [c_IN_CW-1:0]  c_IN_FULL  = c_IN_CW'(IN_DEPTH);
    localparam logic [c_OUT_PW-1:0] c_OUT_LAST = c_OUT_PW'(OUT_DEPTH - 1);
    localparam logic [c_OUT_CW-1:0] c_OUT_FULL = c_OUT_CW'(OUT_DEPTH);

    localparam logic [1:0] c_ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] c_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] c_ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] c_ADDR_OUT_STAT = 2'b11;

    // ---------------- input channel (router -> processor) ----------------
    logic [DATA_WIDTH-1:0] r_in_mem [0:IN_DEPTH-1];
    logic [c_IN_PW-1:0]    r_in_wr;
    logic [c_IN_PW-1:0]    r_in_rd;
    logic [c_IN_CW-1:0]    r_in_cnt;

    logic                  w_in_full;
    logic                  w_in_empty;
    logic                  w_in_push;
    logic                  w_in_pop;
    logic [c_IN_PW-1:0]    w_in_wr_nxt;
    logic [c_IN_PW-1:0]    w_in_rd_nxt;
    logic [DATA_WIDTH-1:0] w_in_head;

    assign w_in_full   = (r_in_cnt == c_IN_FULL);
    assign w_in_empty  = (r_in_cnt == '0);
    assign net_ri      = ~w_in_full;
    assign w_in_push   = net_si & ~w_in_full;
    assign w_in_pop    = nicEn & ~nicWrEn & (addr == c_ADDR_IN_DATA) & ~w_in_empty;
    assign w_in_wr_nxt = (r_in_wr == c_IN_LAST) ? '0 : r_in_wr + 1'b1;
    assign w_in_rd_nxt = (r_in_rd == c_IN_LAST) ? '0 : r_in_rd + 1'b1;
    assign w_in_head   = r_in_mem[r_in_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_DEPTH; i++) begin
                r_in_mem[i] <= '0;
            end
            r_in_wr  <= '0;
            r_in_rd  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) begin
                r_in_mem[r_in_wr] <= net_di;
                r_in_wr           <= w_in_wr_nxt;
            end
            if (w_in_pop) begin
                r_in_rd <= w_in_rd_nxt;
            end
            if (w_in_push && !w_in_pop) begin
                r_in_cnt <= r_in_cnt + 1'b1;
            end else if (!w_in_push && w_in_pop) begin
                r_in_cnt <= r_in_cnt - 1'b1;
            end
        end
    end

    // ---------------- output channel (processor -> router) ----------------
    logic [DATA_WIDTH-1:0] r_out_mem [0:OUT_DEPTH-1];
    logic [c_OUT_PW-1:0]   r_out_wr;
    logic [c_OUT_PW-1:0]   r_out_rd;
    logic [c_OUT_CW-1:0]   r_out_cnt;

    logic                  w_out_full;
    logic                  w_out_empty;
    logic                  w_out_push;
    logic                  w_out_send;
    logic [c_OUT_PW-1:0]   w_out_wr_nxt;
    logic [c_OUT_PW-1:0]   w_out_rd_nxt;
    logic [DATA_WIDTH-1:0] w_out_head;

    assign w_out_full   = (r_out_cnt == c_OUT_FULL);
    assign w_out_empty  = (r_out_cnt == '0);
    assign w_out_push   = nicEn & nicWrEn & (addr == c_ADDR_OUT_DATA) & ~w_out_full;
    assign w_out_wr_nxt = (r_out_wr == c_OUT_LAST) ? '0 : r_out_wr + 1'b1;
    assign w_out_rd_nxt = (r_out_rd == c_OUT_LAST) ? '0 : r_out_rd + 1'b1;
    assign w_out_head   = r_out_mem[r_out_rd];

    // The head only leaves on the polarity that matches its VC bit, so a
    // mismatched head blocks everything behind it for one cycle.
    assign w_out_send = ~w_out_empty & net_ro & (w_out_head[DATA_WIDTH-1] == net_polarity);
    assign net_so     = w_out_send;
    assign net_do     = w_out_empty ? '0 : w_out_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_out_mem[i] <= '0;
            end
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) begin
                r_out_mem[r_out_wr] <= d_in;
                r_out_wr            <= w_out_wr_nxt;
            end
            if (w_out_send) begin
                r_out_rd <= w_out_rd_nxt;
            end
            if (w_out_push && !w_out_send) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end else if (!w_out_push && w_out_send) begin
                r_out_cnt <= r_out_cnt - 1'b1;
            end
        end
    end

    // ---------------- processor register map ----------------
    logic [DATA_WIDTH-1:0] w_in_status;
    logic [DATA_WIDTH-1:0] w_out_status;

    always_comb begin
        w_in_status        = '0;
        w_in_status[0]     = ~w_in_empty;
        w_in_status[15:8]  = 8'(r_in_cnt);
        w_out_status       = '0;
        w_out_status[0]    = w_out_full;
        w_out_status[15:8] = 8'(r_out_cnt);
    end

    always_comb begin
        d_out = '0;
        if (nicEn && !nicWrEn) begin
            case (addr)
                c_ADDR_IN_DATA:  d_out = w_in_head;
                c_ADDR_IN_STAT:  d_out = w_in_status;
                c_ADDR_OUT_DATA: d_out = w_out_head;
                c_ADDR_OUT_STAT: d_out = w_out_status;
                default:         d_out = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_cardinal_nic                                              |
// | Description : Self-checking bench for cardinal_nic: queue-based model with |
// |               per-cycle compare plus directed hand-computed expectations.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cardinal_nic;

    localparam int DW        = 64;
    localparam int IN_DEPTH  = 2;
    localparam int OUT_DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          nicEn;
    logic          nicWrEn;
    logic          net_si;
    logic          net_ri;
    logic [DW-1:0] net_di;
    logic          net_so;
    logic          net_ro;
    logic [DW-1:0] net_do;
    logic          net_polarity;

    cardinal_nic #(
        .DATA_WIDTH (DW),
        .IN_DEPTH   (IN_DEPTH),
        .OUT_DEPTH  (OUT_DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_viol   = 0;
    bit model_valid = 1'b0;
    bit pol_toggle  = 1'b0;

    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] sent_q[$];
    logic          sent_pol[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Status word as the processor should see it: count in [15:8], flag in bit 0.
    function automatic logic [DW-1:0] status_word(input int cnt, input bit flag);
        return (DW'(cnt) << 8) | DW'(flag);
    endfunction

    // {valid, data}: valid=0 when the expected read value is a stale slot.
    function automatic logic [DW:0] exp_dout();
        if (!(nicEn && !nicWrEn)) return {1'b1, {DW{1'b0}}};
        case (addr)
            2'd0:    return (in_q.size() > 0)  ? {1'b1, in_q[0]}  : {1'b0, {DW{1'b0}}};
            2'd1:    return {1'b1, status_word(in_q.size(), in_q.size() > 0)};
            2'd2:    return (out_q.size() > 0) ? {1'b1, out_q[0]} : {1'b0, {DW{1'b0}}};
            default: return {1'b1, status_word(out_q.size(), out_q.size() == OUT_DEPTH)};
        endcase
    endfunction

    function automatic bit exp_send();
        if (out_q.size() == 0) return 1'b0;
        return net_ro && (out_q[0][DW-1] == net_polarity);
    endfunction

    // Model state advance at each active edge, from pre-edge state and inputs.
    always @(posedge clk) begin
        automatic bit in_pop   = nicEn && !nicWrEn && addr == 2'd0 && in_q.size() > 0;
        automatic bit in_push  = net_si && in_q.size() < IN_DEPTH;
        automatic bit out_push = nicEn && nicWrEn && addr == 2'd2 && out_q.size() < OUT_DEPTH;
        automatic bit out_send = exp_send();
        if (rst) begin
            in_q.delete();
            out_q.delete();
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (net_si && !in_push) n_viol <= n_viol + 1;
            if (in_pop)   void'(in_q.pop_front());
            if (out_send) void'(out_q.pop_front());
            if (in_push)  in_q.push_back(net_di);
            if (out_push) out_q.push_back(d_in);
        end
    end

    // Per-cycle compare, mid-cycle, against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            automatic logic [DW:0] ed = exp_dout();
            chk("net_ri", DW'(net_ri), DW'(in_q.size() < IN_DEPTH));
            chk("net_so", DW'(net_so), DW'(exp_send()));
            chk("net_do", net_do, (out_q.size() > 0) ? out_q[0] : '0);
            if (ed[DW]) chk("d_out", d_out, ed[DW-1:0]);
        end
        if (!rst && net_so) begin
            sent_q.push_back(net_do);
            sent_pol.push_back(net_polarity);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (pol_toggle) net_polarity = ~net_polarity;
    endtask

    task automatic bus_idle();
        nicEn   = 1'b0;
        nicWrEn = 1'b0;
        addr    = 2'd0;
        d_in    = '0;
    endtask

    task automatic peek(input logic [1:0] a, input logic [DW-1:0] exp, input string nm);
        nicEn   = 1'b1;
        nicWrEn = 1'b0;
        addr    = a;
        #1;
        chk(nm, d_out, exp);
    endtask

    task automatic write_out(input logic [DW-1:0] w);
        nicEn   = 1'b1;
        nicWrEn = 1'b1;
        addr    = 2'd2;
        d_in    = w;
        step();
        bus_idle();
    endtask

    localparam logic [DW-1:0] W_AA = 64'h8000_0000_0000_00AA;
    localparam logic [DW-1:0] W_B1 = 64'h8000_0000_0000_0001;
    localparam logic [DW-1:0] W_B2 = 64'h0000_0000_0000_0002;
    localparam logic [DW-1:0] W_B3 = 64'h0000_0000_0000_0003;
    localparam logic [DW-1:0] W_R  = 64'h8000_0000_0000_0055;

    initial begin
        int n_sent;
        // Reset with traffic attempted on both channels.
        rst = 1'b1; net_si = 1'b1; net_di = 64'hDEAD; net_ro = 1'b0; net_polarity = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'hBEEF;
        step();
        step();
        rst = 1'b0; net_si = 1'b0; bus_idle();
        #1;
        chk("rst_net_ri", DW'(net_ri), 1);
        chk("rst_net_so", DW'(net_so), 0);
        chk("rst_net_do", net_do, 0);
        chk("rst_d_out_idle", d_out, 0);
        peek(2'd1, 64'h0, "rst_in_status");
        peek(2'd3, 64'h0, "rst_out_status");
        step();
        bus_idle();

        // Input fill / drain.
        net_si = 1'b1; net_di = 64'h1; step();
        net_di = 64'h2; step();
        net_si = 1'b0;
        chk("fill_net_ri", DW'(net_ri), 0);
        peek(2'd1, 64'h201, "fill_in_status");
        peek(2'd0, 64'h1, "drain_head0");
        step();
        peek(2'd0, 64'h2, "drain_head1");
        step();
        peek(2'd1, 64'h0, "drain_in_status");
        bus_idle();
        step();

        // Output polarity gating.
        pol_toggle = 1'b1; net_ro = 1'b1;
        sent_q.delete(); sent_pol.delete();
        write_out(W_AA);
        for (int i = 0; i < 6; i++) step();
        chk("pol_sent_cnt", DW'(sent_q.size()), 1);
        if (sent_q.size() == 1) begin
            chk("pol_sent_data", sent_q[0], W_AA);
            chk("pol_sent_pol", DW'(sent_pol[0]), 1);
        end
        peek(2'd3, 64'h0, "pol_out_status");
        bus_idle();

        // Backpressure, dropped write, then ordered drain.
        net_ro = 1'b0;
        step();
        write_out(W_B1);
        write_out(W_B2);
        peek(2'd3, 64'h201, "bp_out_full");
        write_out(W_B3);
        peek(2'd3, 64'h201, "bp_after_drop");
        bus_idle();
        sent_q.delete(); sent_pol.delete();
        net_ro = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("bp_sent_cnt", DW'(sent_q.size()), 2);
        if (sent_q.size() == 2) begin
            chk("bp_sent0", sent_q[0], W_B1);
            chk("bp_pol0", DW'(sent_pol[0]), 1);
            chk("bp_sent1", sent_q[1], W_B2);
            chk("bp_pol1", DW'(sent_pol[1]), 0);
        end
        peek(2'd3, 64'h0, "bp_out_empty");
        bus_idle();
        pol_toggle = 1'b0; net_ro = 1'b0;
        step();

        // Simultaneous pop with a push attempt while full.
        net_si = 1'b1; net_di = 64'h10; step();
        net_di = 64'h11; step();
        net_di = 64'h12;
        peek(2'd0, 64'h10, "sim_head");
        chk("sim_ri_full", DW'(net_ri), 0);
        step();
        bus_idle();
        #1;
        chk("sim_ri_freed", DW'(net_ri), 1);
        step();
        net_si = 1'b0;
        peek(2'd1, 64'h201, "sim_count2");
        peek(2'd0, 64'h11, "sim_head1");
        step();
        peek(2'd0, 64'h12, "sim_head2");
        step();
        bus_idle();
        step();

        // Mid-operation reset while a send is offered.
        net_polarity = 1'b1;
        net_si = 1'b1; net_di = 64'h20;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = W_R;
        step();
        net_si = 1'b0; bus_idle(); net_ro = 1'b1;
        #1;
        chk("mr_so_before", DW'(net_so), 1);
        n_sent = sent_q.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_no_transfer", DW'(sent_q.size()), DW'(n_sent));
        chk("mr_net_ri", DW'(net_ri), 1);
        chk("mr_net_so", DW'(net_so), 0);
        peek(2'd1, 64'h0, "mr_in_status");
        peek(2'd3, 64'h0, "mr_out_status");
        bus_idle();
        step();
        step();

        $display("router protocol violations observed: %0d", n_viol);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
